// File: rtl/hs_tx_pkg.sv
// hs_tx_pkg: shared states, byte constants and timer width for the D-PHY HS lane sequencer
package hs_tx_pkg;
    typedef enum logic [2:0] {STOP, HS_RQST, HS_PREP, HS_ZERO, SYNC, DATA, TRAIL, EXIT} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam logic [7:0] HS_ZERO_BYTE = 8'h00;
    localparam int TMR_W = 8;
    // Trail holds the inverse of the last serialized bit; bytes go out LSB-first so that is bit 7
    function automatic logic [7:0] trail_byte(input logic [7:0] last);
        return {8{~last[7]}};
    endfunction
endpackage

// File: rtl/hs_tx_sequencer_if.sv
// hs_tx_sequencer_if: PPI application side plus serializer/LP line side of one data lane
interface hs_tx_sequencer_if;
    logic       TxRequestHS;
    logic [7:0] TxDataHS;
    logic       TxReadyHS;
    logic       Enable;
    logic [7:0] TX_BYTE_DATA;
    logic       HS_EN;
    logic       LP_DP;
    logic       LP_DN;
    logic       Stopstate;
    modport master (output TxRequestHS, TxDataHS,
                    input TxReadyHS, Enable, TX_BYTE_DATA, HS_EN, LP_DP, LP_DN, Stopstate);
    modport slave (input TxRequestHS, TxDataHS,
                   output TxReadyHS, Enable, TX_BYTE_DATA, HS_EN, LP_DP, LP_DN, Stopstate);
endinterface

// File: rtl/hs_state_timer.sv
// hs_state_timer: down-counter shared by all timed lane states; done when it reaches zero
module hs_state_timer
    import hs_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);
    logic [TMR_W-1:0] cnt;
    // Load on state entry, then count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign done = (cnt == '0);
endmodule

// File: rtl/hs_tx_sequencer.sv
// hs_tx_sequencer: sequences one D-PHY data lane through LP request, HS preamble, payload and trail
module hs_tx_sequencer
    import hs_tx_pkg::*;
#(
    parameter int T_LPX        = 2,
    parameter int T_HS_PREPARE = 2,
    parameter int T_HS_ZERO    = 4,
    parameter int T_HS_TRAIL   = 3,
    parameter int T_HS_EXIT    = 2
) (
    input  logic                 TX_BYTE_clk,
    input  logic                 TX_rst_n,
    hs_tx_sequencer_if.slave     lane
);
    state_t           state;
    logic             load;
    logic [TMR_W-1:0] load_val;
    logic             done;
    logic [7:0]       last_byte;
    logic [7:0]       tx_data;
    logic             en, hs_en, lp_dp, lp_dn, stop;
    logic             req;
    assign req = lane.TxRequestHS;
    hs_state_timer u_timer (
        .clk      (TX_BYTE_clk),
        .rst_n    (TX_rst_n),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );
    // Arm the timer with the duration of whichever timed state is entered next
    always_comb begin
        load = 1'b0;
        load_val = '0;
        unique case (state)
            STOP:       begin load = req;  load_val = TMR_W'(T_LPX - 1);        end
            HS_RQST:    begin load = done; load_val = TMR_W'(T_HS_PREPARE - 1); end
            HS_PREP:    begin load = done; load_val = TMR_W'(T_HS_ZERO - 1);    end
            SYNC, DATA: begin load = !req; load_val = TMR_W'(T_HS_TRAIL - 1);   end
            TRAIL:      begin load = done; load_val = TMR_W'(T_HS_EXIT - 1);    end
            default:    ;
        endcase
    end
    // Lane FSM; outputs are set on the transition edge so they are registered with the state
    always_ff @(posedge TX_BYTE_clk or negedge TX_rst_n) begin
        if (!TX_rst_n) begin
            state <= STOP;
            last_byte <= 8'h00;
            tx_data <= 8'h00;
            en <= 1'b0;
            hs_en <= 1'b0;
            lp_dp <= 1'b1;
            lp_dn <= 1'b1;
            stop <= 1'b1;
        end else begin
            unique case (state)
                STOP: if (req) begin
                    state <= HS_RQST;
                    lp_dp <= 1'b0;
                    stop <= 1'b0;
                end
                HS_RQST: if (done) begin
                    state <= HS_PREP;
                    lp_dn <= 1'b0;
                end
                HS_PREP: if (done) begin
                    state <= HS_ZERO;
                    hs_en <= 1'b1;
                    en <= 1'b1;
                    tx_data <= HS_ZERO_BYTE;
                end
                HS_ZERO: if (done) begin
                    state <= SYNC;
                    tx_data <= SYNC_BYTE;
                end
                SYNC: if (req) begin
                    state <= DATA;
                    tx_data <= lane.TxDataHS;
                end else begin
                    state <= TRAIL;
                    last_byte <= SYNC_BYTE;
                    tx_data <= trail_byte(SYNC_BYTE);
                end
                DATA: if (req) tx_data <= lane.TxDataHS;
                else begin
                    state <= TRAIL;
                    last_byte <= tx_data;
                    tx_data <= trail_byte(tx_data);
                end
                TRAIL: if (done) begin
                    state <= EXIT;
                    hs_en <= 1'b0;
                    en <= 1'b0;
                    lp_dp <= 1'b1;
                    lp_dn <= 1'b1;
                    tx_data <= 8'h00;
                end else tx_data <= trail_byte(last_byte);
                EXIT: if (done) begin
                    state <= STOP;
                    stop <= 1'b1;
                end
                default: state <= STOP;
            endcase
        end
    end
    assign lane.TxReadyHS    = (state == SYNC) || (state == DATA);
    assign lane.Enable       = en;
    assign lane.TX_BYTE_DATA = tx_data;
    assign lane.HS_EN        = hs_en;
    assign lane.LP_DP        = lp_dp;
    assign lane.LP_DN        = lp_dn;
    assign lane.Stopstate    = stop;
endmodule

// File: tb/tb_hs_tx_sequencer.sv
// tb_hs_tx_sequencer: vector table plus scoreboarded burst sequences for the HS lane sequencer
module tb_hs_tx_sequencer;
    typedef struct packed {
        logic       dp, dn, hs, en;
        logic [7:0] data;
        logic       rdy, stop;
    } exp_t;
    typedef struct {
        logic       req;
        logic [7:0] din;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t E_STOP, E_RQST, E_PREP, E_ZERO, E_SYNC, E_EXIT;
    vec_t tbl[17];
    logic [7:0] q[$];

    always #5 clk = ~clk;

    hs_tx_sequencer_if lane();
    hs_tx_sequencer dut (.TX_BYTE_clk(clk), .TX_rst_n(rst_n), .lane(lane));

    function automatic exp_t mk(input logic dp, dn, hs, en, input logic [7:0] d, input logic rdy, stop);
        return {dp, dn, hs, en, d, rdy, stop};
    endfunction
    function automatic exp_t e_data(input logic [7:0] b);
        return mk(0, 0, 1, 1, b, 1, 0);
    endfunction
    function automatic exp_t e_trail(input logic [7:0] last);
        return mk(0, 0, 1, 1, last[7] ? 8'h00 : 8'hFF, 0, 0);
    endfunction
    function automatic vec_t v(input logic req, input logic [7:0] din, input exp_t e);
        vec_t r;
        r.req = req; r.din = din; r.e = e;
        return r;
    endfunction

    // LP levels are not checked while HS drives the lane; the byte only while the serializer is enabled
    task automatic check(input string name, input exp_t e, input logic strict);
        exp_t a, m;
        a = {lane.LP_DP, lane.LP_DN, lane.HS_EN, lane.Enable, lane.TX_BYTE_DATA, lane.TxReadyHS, lane.Stopstate};
        m = '1;
        if (!strict) begin
            if (e.hs) begin m.dp = 1'b0; m.dn = 1'b0; end
            if (!e.en) m.data = 8'h00;
        end
        checks++;
        if ((a & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s: got dp/dn/hs/en/data/rdy/stop=%b/%b/%b/%b/%h/%b/%b required %b/%b/%b/%b/%h/%b/%b",
                     name, a.dp, a.dn, a.hs, a.en, a.data, a.rdy, a.stop,
                     e.dp, e.dn, e.hs, e.en, e.data, e.rdy, e.stop);
        end
    endtask

    task automatic step(input string name, input logic req, input logic [7:0] din, input exp_t e);
        exp_t x;
        lane.TxRequestHS = req;
        lane.TxDataHS = din;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check(name, x, 1'b0);
    endtask

    task automatic burst(input string tag, input logic [7:0] p[$], input logic early_drop, input logic hold);
        logic r;
        logic [7:0] last;
        r = !early_drop;
        last = 8'hB8;
        step({tag, " rqst0"}, 1, 0, E_RQST);
        step({tag, " rqst1"}, 1, 0, E_RQST);
        step({tag, " prep0"}, 1, 0, E_PREP);
        step({tag, " prep1"}, r, 0, E_PREP);
        for (int i = 0; i < 4; i++) step($sformatf("%s zero%0d", tag, i), r, 0, E_ZERO);
        step({tag, " sync"}, r, 0, E_SYNC);
        foreach (p[i]) begin
            step($sformatf("%s data%0d", tag, i), 1, p[i], e_data(p[i]));
            last = p[i];
        end
        step({tag, " trail0"}, 0, 8'h5A, e_trail(last));
        step({tag, " trail1"}, hold, 0, e_trail(last));
        step({tag, " trail2"}, hold, 0, e_trail(last));
        step({tag, " exit0"}, hold, 0, E_EXIT);
        step({tag, " exit1"}, hold, 0, E_EXIT);
        step({tag, " stop"}, hold, 0, E_STOP);
    endtask

    initial begin
        E_STOP = mk(1, 1, 0, 0, 8'h00, 0, 1);
        E_RQST = mk(0, 1, 0, 0, 8'h00, 0, 0);
        E_PREP = mk(0, 0, 0, 0, 8'h00, 0, 0);
        E_ZERO = mk(0, 0, 1, 1, 8'h00, 0, 0);
        E_SYNC = mk(0, 0, 1, 1, 8'hB8, 1, 0);
        E_EXIT = mk(1, 1, 0, 0, 8'h00, 0, 0);
        tbl[0]  = v(1, 8'h00, E_RQST);
        tbl[1]  = v(1, 8'h00, E_RQST);
        tbl[2]  = v(1, 8'h00, E_PREP);
        tbl[3]  = v(1, 8'h00, E_PREP);
        tbl[4]  = v(1, 8'h00, E_ZERO);
        tbl[5]  = v(1, 8'h00, E_ZERO);
        tbl[6]  = v(1, 8'h00, E_ZERO);
        tbl[7]  = v(1, 8'h00, E_ZERO);
        tbl[8]  = v(1, 8'h77, E_SYNC);
        tbl[9]  = v(1, 8'hA5, mk(0, 0, 1, 1, 8'hA5, 1, 0));
        tbl[10] = v(1, 8'h3C, mk(0, 0, 1, 1, 8'h3C, 1, 0));
        tbl[11] = v(0, 8'hEE, mk(0, 0, 1, 1, 8'hFF, 0, 0));
        tbl[12] = v(0, 8'h00, mk(0, 0, 1, 1, 8'hFF, 0, 0));
        tbl[13] = v(0, 8'h00, mk(0, 0, 1, 1, 8'hFF, 0, 0));
        tbl[14] = v(0, 8'h00, E_EXIT);
        tbl[15] = v(0, 8'h00, E_EXIT);
        tbl[16] = v(0, 8'h00, E_STOP);

        lane.TxRequestHS = 1'b0;
        lane.TxDataHS = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", E_STOP, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle stop", 0, 0, E_STOP);

        for (int i = 0; i < 17; i++) step($sformatf("s1 row%0d", i), tbl[i].req, tbl[i].din, tbl[i].e);

        q.delete(); q.push_back(8'h12); q.push_back(8'h80);
        burst("s2", q, 1'b0, 1'b0);

        q.delete();
        burst("s3", q, 1'b1, 1'b0);

        q.delete(); q.push_back(8'h11);
        burst("s4a", q, 1'b0, 1'b1);
        q.delete(); q.push_back(8'hA5); q.push_back(8'h3C);
        burst("s4b", q, 1'b0, 1'b0);

        step("s5 rqst0", 1, 0, E_RQST);
        step("s5 rqst1", 1, 0, E_RQST);
        step("s5 prep0", 1, 0, E_PREP);
        step("s5 prep1", 1, 0, E_PREP);
        for (int i = 0; i < 4; i++) step($sformatf("s5 zero%0d", i), 1, 0, E_ZERO);
        step("s5 sync", 1, 0, E_SYNC);
        step("s5 data0", 1, 8'h5A, e_data(8'h5A));
        step("s5 data1", 1, 8'hC3, e_data(8'hC3));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s5 async reset", E_STOP, 1'b1);
        @(posedge clk);
        #1;
        check("s5 reset held", E_STOP, 1'b1);
        lane.TxRequestHS = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("s5 no trail%0d", i), 0, 0, E_STOP);

        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        burst("s6", q, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hs_tx_sequencer.md
Name: hs_tx_sequencer

Overview:
Byte-clock controller that sequences one MIPI D-PHY data lane through a complete high-speed burst. The burst runs LP-11 stop, then LP-01 request, LP-00 prepare, HS-zero, sync byte, payload, HS-trail, HS-exit, and back to stop. It drives the Serializer's Enable and TX_BYTE_DATA inputs, along with the LP line levels and the HS driver enable. On the application side it offers a PPI-style TxRequestHS/TxReadyHS/TxDataHS interface.

Parameters:
T_LPX, 2, LP-01 request duration in TX_BYTE_clk cycles (1..255)
T_HS_PREPARE, 2, LP-00 prepare duration in cycles (1..255)
T_HS_ZERO, 4, HS-zero (0x00 bytes) duration in cycles (1..255)
T_HS_TRAIL, 3, HS-trail duration in cycles (1..255)
T_HS_EXIT, 2, post-burst LP-11 hold before a new request is accepted (1..255)

Ports:
TX_BYTE_clk  in  1  byte clock; all logic on rising edge
TX_rst_n  in  1  asynchronous active-low reset
TxRequestHS  in  1  application burst request; held high for the burst, dropped after the last byte
TxDataHS  in  8  payload byte; consumed when TxRequestHS & TxReadyHS at an edge
TxReadyHS  out  1  payload accept strobe
Enable  out  1  Serializer enable
TX_BYTE_DATA  out  8  byte to the Serializer
HS_EN  out  1  HS driver enable (LP drivers tri-stated when 1)
LP_DP  out  1  LP Dp level
LP_DN  out  1  LP Dn level
Stopstate  out  1  lane in STOP (LP-11, idle)

Behaviour:
- Reset (async, any state): state=STOP, counter=0, TX_BYTE_DATA=8'h00, last_byte=8'h00.
  - Outputs in reset: Enable=0, HS_EN=0, LP_DP=1, LP_DN=1, TxReadyHS=0, Stopstate=1.
  - Reset mid-burst aborts immediately; no trail is emitted.
- All outputs are registered (Moore).
  - Exception: TxReadyHS = (state==SYNC || state==DATA), decoded from the state register.
- Timed states: on entry the counter loads T_x-1. The state is left on the edge where counter==0, so it lasts exactly T_x cycles.
- State outputs (LP_DP/LP_DN, HS_EN, Enable, TX_BYTE_DATA):
  - STOP: 1/1, HS_EN=0, Enable=0. Stopstate=1. TxRequestHS=1 at an edge -> HS_RQST.
  - HS_RQST: LP 0/1 for T_LPX -> HS_PREP.
  - HS_PREP: LP 0/0 for T_HS_PREPARE -> HS_ZERO.
  - HS_ZERO: HS_EN=1, Enable=1, TX_BYTE_DATA=8'h00 for T_HS_ZERO -> SYNC.
  - SYNC: TX_BYTE_DATA=8'hB8, one cycle, TxReadyHS=1.
    - If TxRequestHS=1 at the edge: capture TxDataHS -> DATA.
    - Otherwise -> TRAIL with last_byte=8'hB8 (zero-payload burst).
  - DATA: TX_BYTE_DATA = byte captured at the previous edge; TxReadyHS=1.
    - TxRequestHS=1 at an edge: capture the next byte, stay.
    - TxRequestHS=0 at an edge: -> TRAIL; last_byte = byte currently on TX_BYTE_DATA.
  - TRAIL: TX_BYTE_DATA = {8{~last_byte[7]}} (bit7 is the last serialized bit, LSB-first) for T_HS_TRAIL -> EXIT.
  - EXIT: HS_EN=0, Enable=0, LP 1/1, Stopstate=0, TxRequestHS ignored, for T_HS_EXIT -> STOP.
- TxRequestHS dropped during HS_RQST/HS_PREP/HS_ZERO: the sequence still completes through SYNC, then proceeds as a zero-payload burst.
- TxRequestHS held high through EXIT: the next burst starts on the first edge in STOP (one STOP cycle minimum between bursts).
- TxDataHS is sampled only when TxReadyHS=1; its value elsewhere is don't-care.
- No byte loss: every edge with TxRequestHS&TxReadyHS puts exactly one byte on TX_BYTE_DATA, in order, for exactly one cycle.

Decomposition:
- Package hs_tx_pkg:
  - state enum: STOP, HS_RQST, HS_PREP, HS_ZERO, SYNC, DATA, TRAIL, EXIT
  - constants SYNC_BYTE=8'hB8, HS_ZERO_BYTE=8'h00
  - timer width TMR_W=8
- Sub-module hs_state_timer: load value, load strobe, done flag (counter==0). Used for all five timed states.

Test Plan:
1. Reset with defaults; assert TxRequestHS; send 8'hA5, 8'h3C, then drop.
   -> LP 0/1 ×2, 0/0 ×2, 00 ×4, B8 ×1, A5, 3C.
   -> Trail 8'hFF ×3 (3C bit7=0).
   -> EXIT ×2, then STOP with Stopstate=1.
2. Payload ending in 8'h80. -> trail bytes 8'h00 ×3.
3. Drop TxRequestHS during HS_PREP. -> zero-payload burst: 00 ×4, B8, then trail 8'h00 ×3; TxReadyHS high only during the SYNC cycle.
4. Hold TxRequestHS high through EXIT. -> exactly one STOP cycle, then HS_RQST; the second burst is identical to scenario 1's preamble.
5. Assert TX_rst_n=0 mid-DATA (between clock edges). -> outputs reach reset values immediately (asynchronously): LP 1/1, Enable=0, HS_EN=0, TX_BYTE_DATA=00, no trail emitted.
6. Send a 256-byte incrementing payload 00..FF. -> TX_BYTE_DATA reproduces the sequence, one byte per cycle with no gaps, then trail 8'h00 ×3 (FF bit7=1).
